// File: rtl/movebit_seq.sv
// Iterative MOVEBIT unit: popcount of imm16 drives inverting the top c bits of rs,
// then an arithmetic right shift by c, one immediate bit or shift step per cycle.
module movebit_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rs_val,
    input  logic [15:0] imm16,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StShift,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rs_q, rs_d;
    logic [15:0] imm_q, imm_d;
    logic [31:0] mask_q, mask_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] work_q, work_d;
    logic [31:0] result_q, result_d;

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        imm_d    = imm_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        work_d   = work_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rs_d    = rs_val;
                    imm_d   = imm16;
                    mask_d  = 32'h0;
                    cnt_d   = 5'd0;
                    idx_d   = 4'd0;
                    state_d = StCount;
                end
            end
            StCount: begin
                // Each set immediate bit extends the inversion mask down from bit 31.
                if (imm_q[0]) begin
                    cnt_d  = cnt_q + 5'd1;
                    mask_d = {1'b1, mask_q[31:1]};
                end
                imm_d = imm_q >> 1;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    work_d  = rs_q ^ mask_d;
                    state_d = (cnt_d != 5'd0) ? StShift : StDone;
                end
            end
            StShift: begin
                work_d = {work_q[31], work_q[31:1]};
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Result register captures only on the edge that enters DONE.
        if (state_d == StDone && state_q != StDone) begin
            result_d = work_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            rs_q     <= 32'h0;
            imm_q    <= 16'h0;
            mask_q   <= 32'h0;
            cnt_q    <= 5'd0;
            idx_q    <= 4'd0;
            work_q   <= 32'h0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            imm_q    <= imm_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_movebit_seq.sv
// Bench for movebit_seq: fixed vectors, random ops against a behavioural model,
// and hand sequences for busy-ignore, back-to-back and mid-operation reset.
module tb_movebit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] rs_val;
    logic [15:0] imm16;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    movebit_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rs_val (rs_val),
        .imm16  (imm16),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [15:0] imm;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] model(input logic [31:0] rs, input logic [15:0] imm);
        int          c;
        logic [31:0] t;
        c = $countones(imm);
        if (c == 0) return rs;
        t = rs ^ (32'hFFFF_FFFF << (32 - c));
        return $signed(t) >>> c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE; returns done cycle (-1 on timeout) and result seen with done.
    task automatic run_op(input logic [31:0] rs, input logic [15:0] imm,
                          output logic [31:0] res, output int lat, output logic busy_ok);
        rs_val  = rs;
        imm16   = imm;
        start   = 1'b1;
        lat     = -1;
        res     = 32'hx;
        busy_ok = 1'b1;
        step();
        start   = 1'b0;
        rs_val  = ~rs;
        imm16   = ~imm;
        for (int k = 1; k <= 40; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic do_op(input string name, input logic [31:0] rs, input logic [15:0] imm,
                         input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        run_op(rs, imm, res, lat, busy_ok);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, res, exp);
        check({name, " busy"}, {31'b0, busy_ok}, 32'd1);
        check({name, " idle after"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] rs_r;
        logic [15:0] imm_r;
        int          done_cyc[$];
        logic [31:0] done_res[$];

        vecs[0] = '{32'h1234_5678, 16'h0000, 32'h1234_5678, 17};
        vecs[1] = '{32'h0000_000F, 16'h0003, 32'hF000_0003, 19};
        vecs[2] = '{32'hFFFF_0000, 16'h00FF, 32'h0000_FF00, 25};
        vecs[3] = '{32'h0000_0000, 16'hFFFF, 32'hFFFF_FFFF, 33};
        vecs[4] = '{32'h7FFF_FFFF, 16'h8000, 32'hFFFF_FFFF, 18};
        vecs[5] = '{32'hAAAA_AAAA, 16'h0101, 32'h1AAA_AAAA, 19};

        reset  = 1'b0;
        start  = 1'b1;
        rs_val = 32'hDEAD_BEEF;
        imm16  = 16'h00FF;
        step();
        step();
        check("reset busy/done", {30'b0, busy, done}, 32'd0);
        check("reset result", result, 32'h0);
        reset = 1'b1;
        start = 1'b0;
        step();
        check("idle after reset", {30'b0, busy, done}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].rs, vecs[i].imm, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 30; i++) begin
            rs_r = $urandom;
            unique case (i % 3)
                0:       imm_r = 16'($urandom);
                1:       imm_r = 16'($urandom & $urandom & $urandom);
                default: imm_r = 16'($urandom | $urandom);
            endcase
            do_op($sformatf("rand%0d", i), rs_r, imm_r, model(rs_r, imm_r),
                  17 + $countones(imm_r));
        end

        // Start while busy is ignored; restart right after DONE is accepted.
        done_cyc.delete();
        done_res.delete();
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (done) begin
                done_cyc.push_back(cyc);
                done_res.push_back(result);
            end
            if (cyc == 19) check("b2b idle before restart", {31'b0, busy}, 32'd0);
            start  = (cyc == 0 || cyc == 5 || cyc == 19);
            rs_val = (cyc == 0) ? 32'h8000_0000 : 32'h1;
            imm16  = (cyc == 0) ? 16'h0001 : 16'h0000;
            step();
        end
        check("b2b done count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) begin
            check("b2b first cycle", 32'(done_cyc[0]), 32'd18);
            check("b2b first result", done_res[0], 32'h0);
            check("b2b second cycle", 32'(done_cyc[1]), 32'd36);
            check("b2b second result", done_res[1], 32'h1);
        end

        // Reset mid-operation discards the op; a fresh op then completes normally.
        done_cyc.delete();
        done_res.delete();
        for (int cyc = 0; cyc <= 35; cyc++) begin
            if (done) begin
                done_cyc.push_back(cyc);
                done_res.push_back(result);
            end
            if (cyc == 11) begin
                check("mid reset busy", {31'b0, busy}, 32'd0);
                check("mid reset result", result, 32'h0);
            end
            reset  = (cyc != 10);
            start  = (cyc == 0 || cyc == 12);
            rs_val = 32'h0000_000F;
            imm16  = 16'h0003;
            step();
        end
        check("rst done count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() == 1) begin
            check("rst done cycle", 32'(done_cyc[0]), 32'd31);
            check("rst done result", done_res[0], 32'hF000_0003);
        end

        // Reset wins over start in the same cycle.
        reset = 1'b0;
        start = 1'b1;
        step();
        reset = 1'b1;
        start = 1'b0;
        check("reset over start", {30'b0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/movebit_seq.md
# movebit_seq

Multi-cycle sequencer for the MOVEBIT custom instruction: popcount-driven invert-and-arithmetic-shift of a 32-bit register operand. It replaces the single-cycle combinational popcount plus barrel-shift path with an iterative unit that processes one immediate bit or one shift step per cycle. It sits beside the ALU and is driven by the controller through a start/busy/done handshake, like the multiply/divide unit. The stall logic holds the pipeline while `busy` is high.

## Interface
- Parameters: none. Operand width is fixed at 32 bits and the immediate at 16 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `rs_val`  in  32  register operand; latched on accept.
- `imm16`  in  16  immediate; latched on accept.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  last completed result; holds until the next completion.

## Operation
- Function: c = popcount(imm16), range 0..16.
  - If c = 0: result = rs.
  - Otherwise: form t = rs with bits [31:32-c] inverted, then result = signed(t) >>> c. The fill bit is t[31], which is ~rs[31].
- States: IDLE, COUNT, SHIFT, DONE.
- IDLE:
  - On `start`=1, latch rs_reg←rs_val, imm_reg←imm16, mask←0, cnt←0, idx←0.
  - Go to COUNT.
- COUNT, one cycle per immediate bit:
  - If imm_reg[0]=1: cnt←cnt+1 and mask←{1'b1, mask[31:1]}.
  - Then imm_reg←imm_reg>>1 and idx←idx+1.
  - When the bit processed is idx=15, set work←rs_reg ^ mask_next, where mask_next includes that bit's update.
  - Next state is SHIFT if cnt_next≠0, else DONE.
- SHIFT:
  - Each cycle: work←{work[31], work[31:1]} and cnt←cnt−1.
  - When cnt=1 (last step), go to DONE.
- DONE:
  - `done`=1 and `result`=work, taken from the result register loaded on DONE entry.
  - Next state is always IDLE.
- Width rules: cnt is 5 bits (max 16). idx is 4 bits and never wraps in use. mask has at most 16 top bits set.
- `start` in COUNT, SHIFT or DONE is ignored, with no queuing. Operands changing after accept have no effect.
- `start` in IDLE in the cycle immediately after DONE is accepted normally (back-to-back).
- Reset (`reset`=0 at an edge), including mid-operation:
  - state←IDLE, busy=0, done=0, result=0x00000000, cnt/idx/mask/work←0.
  - An in-flight operation is discarded with no `done`.
- Reset has priority over `start` in the same cycle.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycles 1..16: COUNT, busy=1.
- Cycles 17..16+c: SHIFT.
- Cycle 17+c: DONE, with done=1, busy=1 and result valid.
- Cycle 18+c: IDLE, busy=0.
- Latency from accept to done is 17+c cycles: minimum 17 (c=0), maximum 33 (c=16).
- `result` updates only on the edge entering DONE and is stable otherwise.
- `done` is never high for more than one cycle per accepted start.
- Reset values: busy=0, done=0, result=0.

## Test plan
- rs=0x12345678, imm=0x0000, start at cycle 0 -> done at cycle 17, result=0x12345678, busy low at cycle 18.
- rs=0x0000000F, imm=0x0003 (c=2) -> invert gives 0xC000000F; done at cycle 19, result=0xF0000003.
- rs=0xFFFF0000, imm=0x00FF (c=8) -> done at cycle 25, result=0x0000FF00.
- rs=0x00000000, imm=0xFFFF (c=16) -> done at cycle 33, result=0xFFFFFFFF.
- Busy and back-to-back cases:
  - Start rs=0x80000000, imm=0x0001 (c=1).
  - Pulse `start` with rs=0x1, imm=0x0 at cycle 5 -> ignored.
  - First op: done at cycle 18, result=0x00000000.
  - New start at cycle 19 with rs=0x1, imm=0x0 -> done at cycle 36, result=0x00000001.
- Reset mid-operation:
  - Start rs=0x0000000F, imm=0x0003; drive `reset`=0 at cycle 10 -> busy=0 and result=0 from cycle 11, no done pulse.
  - Release reset and start rs=0x0000000F, imm=0x0003 at cycle 12 -> done at cycle 31, result=0xF0000003.
